// File: rtl/dual_stack_controller.sv
// dual_stack_controller: two LIFO stacks pooled in one single-port RAM.
// Stack A grows up from address 0, stack B grows down from DEPTH-1.
module dual_stack_controller #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int DEPTH_LOG2 = $clog2(DEPTH)
) (
  input  logic                  clock,
  input  logic                  reset,
  output logic                  full,
  output logic                  empty_a,
  output logic                  empty_b,
  output logic [DEPTH_LOG2:0]   count_a,
  output logic [DEPTH_LOG2:0]   count_b,
  input  logic [WIDTH-1:0]      push_a_data,
  input  logic [WIDTH-1:0]      push_b_data,
  input  logic                  push_a_valid,
  input  logic                  push_b_valid,
  output logic                  push_a_ready,
  output logic                  push_b_ready,
  input  logic                  pop_a_valid,
  input  logic                  pop_b_valid,
  output logic                  pop_a_ready,
  output logic                  pop_b_ready,
  output logic [WIDTH-1:0]      pop_a_data,
  output logic [WIDTH-1:0]      pop_b_data,
  output logic                  memory_enable,
  output logic                  memory_write_enable,
  output logic [DEPTH_LOG2-1:0] memory_address,
  output logic [WIDTH-1:0]      memory_write_data,
  input  logic [WIDTH-1:0]      memory_read_data
);

  localparam int CW = DEPTH_LOG2 + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [DEPTH_LOG2-1:0] TOP = DEPTH_LOG2'(DEPTH - 1);
  localparam logic [DEPTH_LOG2-1:0] ONE = DEPTH_LOG2'(1);

  logic [CW-1:0] total;
  logic pop_ok_a, push_ok_a, req_a;
  logic pop_ok_b, push_ok_b, req_b;
  logic grant_a, grant_b, pointer;
  logic [DEPTH_LOG2-1:0] ca_lo, cb_lo;

  // Request qualification and arbitration; pop beats push per stack.
  always_comb begin
    total     = count_a + count_b;
    full      = (total == DEPTH_C);
    empty_a   = (count_a == '0);
    empty_b   = (count_b == '0);
    pop_ok_a  = pop_a_valid & ~empty_a;
    push_ok_a = push_a_valid & ~full;
    pop_ok_b  = pop_b_valid & ~empty_b;
    push_ok_b = push_b_valid & ~full;
    req_a     = pop_ok_a | push_ok_a;
    req_b     = pop_ok_b | push_ok_b;
    grant_a   = ~reset & req_a & (~req_b | ~pointer);
    grant_b   = ~reset & req_b & (~req_a | pointer);
  end

  assign pop_a_ready  = grant_a & pop_ok_a;
  assign push_a_ready = grant_a & ~pop_ok_a;
  assign pop_b_ready  = grant_b & pop_ok_b;
  assign push_b_ready = grant_b & ~pop_ok_b;
  assign pop_a_data   = pop_a_ready ? memory_read_data : '0;
  assign pop_b_data   = pop_b_ready ? memory_read_data : '0;

  // RAM port drive; address arithmetic is modulo the RAM address width.
  always_comb begin
    ca_lo               = count_a[DEPTH_LOG2-1:0];
    cb_lo               = count_b[DEPTH_LOG2-1:0];
    memory_enable       = grant_a | grant_b;
    memory_write_enable = push_a_ready | push_b_ready;
    memory_address      = '0;
    memory_write_data   = '0;
    if (grant_a) begin
      memory_address    = pop_ok_a ? ca_lo - ONE : ca_lo;
      memory_write_data = pop_ok_a ? '0 : push_a_data;
    end else if (grant_b) begin
      memory_address    = pop_ok_b ? TOP - cb_lo + ONE : TOP - cb_lo;
      memory_write_data = pop_ok_b ? '0 : push_b_data;
    end
  end

  // Occupancy counters and round-robin pointer.
  always_ff @(posedge clock) begin
    if (reset) begin
      count_a <= '0;
      count_b <= '0;
      pointer <= 1'b0;
    end else begin
      if (pop_a_ready) count_a <= count_a - CW'(1);
      else if (push_a_ready) count_a <= count_a + CW'(1);
      if (pop_b_ready) count_b <= count_b - CW'(1);
      else if (push_b_ready) count_b <= count_b + CW'(1);
      if (req_a & req_b) pointer <= ~pointer;
    end
  end

endmodule

// File: tb/tb_dual_stack_controller.sv
// tb_dual_stack_controller: directed vector table plus randomized
// traffic checked against a queue-based model of the two stacks.
module tb_dual_stack_controller;

  localparam int W = 8;
  localparam int D = 8;

  logic clock = 1'b0;
  logic reset;
  logic full, empty_a, empty_b;
  logic [3:0] count_a, count_b;
  logic [W-1:0] push_a_data, push_b_data;
  logic push_a_valid, push_b_valid, push_a_ready, push_b_ready;
  logic pop_a_valid, pop_b_valid, pop_a_ready, pop_b_ready;
  logic [W-1:0] pop_a_data, pop_b_data;
  logic memory_enable, memory_write_enable;
  logic [2:0] memory_address;
  logic [W-1:0] memory_write_data, memory_read_data;

  dual_stack_controller #(.WIDTH(W), .DEPTH(D)) dut (
    .clock(clock), .reset(reset), .full(full),
    .empty_a(empty_a), .empty_b(empty_b),
    .count_a(count_a), .count_b(count_b),
    .push_a_data(push_a_data), .push_b_data(push_b_data),
    .push_a_valid(push_a_valid), .push_b_valid(push_b_valid),
    .push_a_ready(push_a_ready), .push_b_ready(push_b_ready),
    .pop_a_valid(pop_a_valid), .pop_b_valid(pop_b_valid),
    .pop_a_ready(pop_a_ready), .pop_b_ready(pop_b_ready),
    .pop_a_data(pop_a_data), .pop_b_data(pop_b_data),
    .memory_enable(memory_enable),
    .memory_write_enable(memory_write_enable),
    .memory_address(memory_address),
    .memory_write_data(memory_write_data),
    .memory_read_data(memory_read_data)
  );

  always #5 clock = ~clock;

  logic [W-1:0] ram [D];
  initial for (int i = 0; i < D; i++) ram[i] = '0;
  always @(posedge clock)
    if (memory_enable && memory_write_enable)
      ram[memory_address] <= memory_write_data;
  assign memory_read_data = ram[memory_address];

  int applied = 0;
  int miscompares = 0;

  typedef struct {
    logic rst; logic pav; logic [7:0] pad;
    logic pbv; logic [7:0] pbd; logic qav; logic qbv;
    logic [3:0] rdy; logic [7:0] da; logic [7:0] db;
    logic [3:0] ca; logic [3:0] cb;
    logic fl; logic en; logic we; logic [2:0] addr;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(
    logic rst, logic pav, logic [7:0] pad, logic pbv, logic [7:0] pbd,
    logic qav, logic qbv, logic [3:0] rdy, logic [7:0] da,
    logic [7:0] db, logic [3:0] ca, logic [3:0] cb, logic fl,
    logic en, logic we, logic [2:0] addr);
    vec_t v;
    v.rst = rst; v.pav = pav; v.pad = pad; v.pbv = pbv; v.pbd = pbd;
    v.qav = qav; v.qbv = qbv; v.rdy = rdy; v.da = da; v.db = db;
    v.ca = ca; v.cb = cb; v.fl = fl; v.en = en; v.we = we;
    v.addr = addr;
    return v;
  endfunction

  function automatic logic [41:0] obs();
    return {push_a_ready, push_b_ready, pop_a_ready, pop_b_ready,
            pop_a_data, pop_b_data, count_a, count_b, full,
            memory_enable, memory_write_enable, memory_address,
            memory_write_data};
  endfunction

  task automatic drive(input logic r, input logic pav,
                       input logic [7:0] pad, input logic pbv,
                       input logic [7:0] pbd, input logic qav,
                       input logic qbv);
    reset = r; push_a_valid = pav; push_a_data = pad;
    push_b_valid = pbv; push_b_data = pbd;
    pop_a_valid = qav; pop_b_valid = qbv;
  endtask

  task automatic tvec(input int idx, input vec_t v);
    logic [41:0] exp;
    logic [7:0] wd;
    drive(v.rst, v.pav, v.pad, v.pbv, v.pbd, v.qav, v.qbv);
    wd = v.rdy[3] ? v.pad : (v.rdy[2] ? v.pbd : 8'h00);
    exp = {v.rdy, v.da, v.db, v.ca, v.cb, v.fl, v.en, v.we, v.addr, wd};
    @(negedge clock);
    applied++;
    if (obs() !== exp) begin
      miscompares++;
      $display("FAIL table vec %0d: got %h want %h", idx, obs(), exp);
    end
    @(posedge clock);
    #1;
  endtask

  logic [7:0] qa[$];
  logic [7:0] qb[$];
  bit ptr;

  task automatic mcycle(input bit r, input bit pav, input logic [7:0] pad,
                        input bit pbv, input logic [7:0] pbd,
                        input bit qav, input bit qbv);
    bit fe, pka, psa, pkb, psb, ra, rb, ga, gb;
    int na, nb, ad;
    logic [7:0] da, db, wd;
    logic [41:0] exp;
    drive(r, pav, pad, pbv, pbd, qav, qbv);
    na = qa.size(); nb = qb.size();
    fe = (na + nb) == D;
    pka = qav && na != 0; psa = pav && !fe; ra = pka || psa;
    pkb = qbv && nb != 0; psb = pbv && !fe; rb = pkb || psb;
    ga = 0; gb = 0;
    if (!r) begin
      if (ra && rb) begin
        if (ptr) gb = 1; else ga = 1;
      end else begin
        ga = ra; gb = rb;
      end
    end
    da = (ga && pka) ? qa[na-1] : 8'h00;
    db = (gb && pkb) ? qb[nb-1] : 8'h00;
    wd = (ga && !pka) ? pad : ((gb && !pkb) ? pbd : 8'h00);
    ad = 0;
    if (ga) ad = pka ? na - 1 : na;
    else if (gb) ad = pkb ? D - nb : D - 1 - nb;
    exp = {ga && !pka, gb && !pkb, ga && pka, gb && pkb, da, db,
           4'(na), 4'(nb), fe, ga || gb, (ga && !pka) || (gb && !pkb),
           3'(ad), wd};
    @(negedge clock);
    applied++;
    if (obs() !== exp || {empty_a, empty_b} !== {na == 0, nb == 0}) begin
      miscompares++;
      $display("FAIL model t=%0t: got %h/%b want %h/%b", $time, obs(),
               {empty_a, empty_b}, exp, {na == 0, nb == 0});
    end
    @(posedge clock);
    if (r) begin
      qa.delete(); qb.delete(); ptr = 0;
    end else begin
      if (ga) begin
        if (pka) qa.pop_back(); else qa.push_back(pad);
      end
      if (gb) begin
        if (pkb) qb.pop_back(); else qb.push_back(pbd);
      end
      if (ra && rb) ptr = !ptr;
    end
    #1;
  endtask

  initial begin
    drive(1, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clock);
    #1;

    vt.push_back(mk(1,1,8'h55,0,0,0,0, 4'b0000,0,0,0,0,0,0,0,0));
    vt.push_back(mk(0,1,8'h11,0,0,0,0, 4'b1000,0,0,0,0,0,1,1,0));
    vt.push_back(mk(0,1,8'h22,0,0,0,0, 4'b1000,0,0,1,0,0,1,1,1));
    vt.push_back(mk(0,1,8'h33,0,0,0,0, 4'b1000,0,0,2,0,0,1,1,2));
    vt.push_back(mk(0,0,0,0,0,1,0, 4'b0010,8'h33,0,3,0,0,1,0,2));
    vt.push_back(mk(0,0,0,0,0,1,0, 4'b0010,8'h22,0,2,0,0,1,0,1));
    vt.push_back(mk(0,0,0,0,0,1,0, 4'b0010,8'h11,0,1,0,0,1,0,0));
    vt.push_back(mk(0,0,0,0,0,1,1, 4'b0000,0,0,0,0,0,0,0,0));
    vt.push_back(mk(0,0,0,1,8'hA0,0,0, 4'b0100,0,0,0,0,0,1,1,7));
    vt.push_back(mk(0,0,0,1,8'hA1,0,0, 4'b0100,0,0,0,1,0,1,1,6));
    vt.push_back(mk(0,0,0,0,0,0,1, 4'b0001,0,8'hA1,0,2,0,1,0,6));
    vt.push_back(mk(0,0,0,0,0,0,1, 4'b0001,0,8'hA0,0,1,0,1,0,7));
    for (int i = 0; i < 5; i++)
      vt.push_back(mk(0,1,8'(i+1),0,0,0,0,
                      4'b1000,0,0,4'(i),0,0,1,1,3'(i)));
    vt.push_back(mk(0,0,0,1,8'hC0,0,0, 4'b0100,0,0,5,0,0,1,1,7));
    vt.push_back(mk(0,0,0,1,8'hC1,0,0, 4'b0100,0,0,5,1,0,1,1,6));
    vt.push_back(mk(0,0,0,1,8'hC2,0,0, 4'b0100,0,0,5,2,0,1,1,5));
    vt.push_back(mk(0,1,8'hEE,1,8'hEE,0,0, 4'b0000,0,0,5,3,1,0,0,0));
    vt.push_back(mk(0,1,8'h99,0,0,0,1, 4'b0001,0,8'hC2,5,3,1,1,0,5));
    vt.push_back(mk(0,1,8'h06,0,0,0,0, 4'b1000,0,0,5,2,0,1,1,5));
    vt.push_back(mk(1,0,0,1,8'h44,1,0, 4'b0000,0,0,6,2,1,0,0,0));
    vt.push_back(mk(0,0,0,0,0,0,0, 4'b0000,0,0,0,0,0,0,0,0));
    vt.push_back(mk(0,1,8'h10,1,8'h20,0,0, 4'b1000,0,0,0,0,0,1,1,0));
    vt.push_back(mk(0,1,8'h11,1,8'h21,0,0, 4'b0100,0,0,1,0,0,1,1,7));
    vt.push_back(mk(0,1,8'h12,1,8'h22,0,0, 4'b1000,0,0,1,1,0,1,1,1));
    vt.push_back(mk(0,1,8'h13,1,8'h23,0,0, 4'b0100,0,0,2,1,0,1,1,6));
    vt.push_back(mk(0,1,8'h77,0,0,1,0, 4'b0010,8'h12,0,2,2,0,1,0,1));
    vt.push_back(mk(0,1,8'h77,0,0,0,0, 4'b1000,0,0,1,2,0,1,1,1));
    vt.push_back(mk(0,0,0,0,0,1,0, 4'b0010,8'h77,0,2,2,0,1,0,1));
    vt.push_back(mk(0,0,0,0,0,0,1, 4'b0001,0,8'h23,1,2,0,1,0,6));

    foreach (vt[i]) tvec(i, vt[i]);

    drive(1, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clock);
    #1;
    qa.delete(); qb.delete(); ptr = 0;

    for (int i = 0; i < 3; i++) mcycle(0, 1, 8'(8'h31 + i), 0, 0, 0, 0);
    for (int i = 0; i < 2; i++) mcycle(0, 0, 0, 1, 8'(8'h41 + i), 0, 0);
    mcycle(1, 1, 8'h5A, 1, 8'h5B, 1, 1);
    mcycle(0, 0, 0, 0, 0, 1, 0);
    mcycle(0, 0, 0, 0, 0, 1, 1);

    for (int i = 0; i < 800; i++)
      mcycle($urandom_range(0, 59) == 0,
             $urandom_range(0, 9) < 6, 8'($urandom),
             $urandom_range(0, 9) < 6, 8'($urandom),
             $urandom_range(0, 9) < 4, $urandom_range(0, 9) < 4);

    $display("== %0d vectors applied, %0d miscompares ==",
             applied, miscompares);
    $finish;
  end

endmodule
